// File: rtl/led_pwm_ctrl.sv
// ---------------------------------------------------------------------------
// led_pwm_ctrl
//
// Purpose:
//    Avalon-MM slave LED controller for the HPS lightweight bridge. Each of
//    the NUM_LEDS outputs is either driven from a static bit or PWM-dimmed
//    from its own duty register. A global enable and an optional blink gate
//    sit in front of every channel. The live LED state and blink phase can
//    be read back through the STATUS register.
//
// Ports:
//    clk_clk         - system clock
//    reset_reset_n   - asynchronous active-low reset
//    avs_address     - word address (5 bits)
//    avs_write       - write strobe, data applied on the next clock edge
//    avs_writedata   - 32-bit write data, bits above each field are dropped
//    avs_read        - read strobe
//    avs_readdata    - read data, valid one cycle after avs_read, then held
//    led_out         - registered LED drive, NUM_LEDS bits
//
// Register map (word address):
//    0x00 CTRL      bit0 enable, bit1 blink_en
//    0x01 STATIC    static value for static-mode LEDs
//    0x02 PRESCALE  prescaler reload R (tick every R+1 clocks)
//    0x03 BLINK     blink half-period H, in PWM frames
//    0x04 MODE      per-LED mode, 1 = PWM, 0 = static
//    0x05 STATUS    read-only, [NUM_LEDS-1:0] led_out, bit16 blink_phase
//    0x08+i         DUTY[i] for i < NUM_LEDS
// ---------------------------------------------------------------------------
module led_pwm_ctrl #(
   parameter int NUM_LEDS      = 8,
   parameter int PWM_BITS      = 8,
   parameter int PRESCALE_BITS = 16,
   parameter int BLINK_BITS    = 8
) (
   input  logic                clk_clk,
   input  logic                reset_reset_n,
   input  logic [4:0]          avs_address,
   input  logic                avs_write,
   input  logic [31:0]         avs_writedata,
   input  logic                avs_read,
   output logic [31:0]         avs_readdata,
   output logic [NUM_LEDS-1:0] led_out
);

   localparam logic [PWM_BITS-1:0]   PWM_MAX   = '1;
   localparam logic [BLINK_BITS-1:0] BLINK_ONE = 1;

   // Programmable registers
   logic                     enable;
   logic                     blink_en;
   logic [NUM_LEDS-1:0]      static_val;
   logic [PRESCALE_BITS-1:0] prescale;
   logic [BLINK_BITS-1:0]    blink_h;
   logic [NUM_LEDS-1:0]      mode;
   logic [PWM_BITS-1:0]      duty [NUM_LEDS];

   // Timebase state
   logic [PRESCALE_BITS-1:0] pre_cnt;
   logic [PWM_BITS-1:0]      pwm_cnt;
   logic [BLINK_BITS-1:0]    blink_cnt;
   logic                     blink_phase;

   logic                     tick;
   logic                     frame_end;
   logic                     wr_ctrl;
   logic                     wr_static;
   logic                     wr_prescale;
   logic                     wr_blink;
   logic                     wr_mode;
   logic [NUM_LEDS-1:0]      pwm_vec;
   logic [NUM_LEDS-1:0]      led_next;
   logic                     gate;
   logic [31:0]              read_word;

   // Only the low bits of each write are stored; fold the whole bus so the
   // dropped upper bits are still visibly consumed.
   logic                     unused_wdata;
   assign unused_wdata = ^avs_writedata;

   assign wr_ctrl     = avs_write && (avs_address == 5'h00);
   assign wr_static   = avs_write && (avs_address == 5'h01);
   assign wr_prescale = avs_write && (avs_address == 5'h02);
   assign wr_blink    = avs_write && (avs_address == 5'h03);
   assign wr_mode     = avs_write && (avs_address == 5'h04);

   // A PRESCALE write restarts the timebase, so a frame end that happens to
   // coincide with it is swallowed along with the tick.
   assign tick      = (pre_cnt == prescale);
   assign frame_end = tick && (pwm_cnt == PWM_MAX) && !wr_prescale;

   // Register file writes. Unmapped addresses (including DUTY slots beyond
   // NUM_LEDS) simply match nothing here and are dropped.
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         enable     <= 1'b0;
         blink_en   <= 1'b0;
         static_val <= '0;
         prescale   <= '0;
         blink_h    <= '0;
         mode       <= '0;
         for (int i = 0; i < NUM_LEDS; i++) begin
            duty[i] <= '0;
         end
      end else begin
         if (wr_ctrl) begin
            enable   <= avs_writedata[0];
            blink_en <= avs_writedata[1];
         end
         if (wr_static) begin
            static_val <= avs_writedata[NUM_LEDS-1:0];
         end
         if (wr_prescale) begin
            prescale <= avs_writedata[PRESCALE_BITS-1:0];
         end
         if (wr_blink) begin
            blink_h <= avs_writedata[BLINK_BITS-1:0];
         end
         if (wr_mode) begin
            mode <= avs_writedata[NUM_LEDS-1:0];
         end
         for (int i = 0; i < NUM_LEDS; i++) begin
            if (avs_write && (avs_address == 5'(i + 8))) begin
               duty[i] <= avs_writedata[PWM_BITS-1:0];
            end
         end
      end
   end

   // Prescaler and PWM counter. A PRESCALE write takes priority over a
   // tick so software always gets a clean frame start from pwm_cnt = 0.
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         pre_cnt <= '0;
         pwm_cnt <= '0;
      end else if (wr_prescale) begin
         pre_cnt <= '0;
         pwm_cnt <= '0;
      end else if (tick) begin
         pre_cnt <= '0;
         pwm_cnt <= pwm_cnt + 1'b1;
      end else begin
         pre_cnt <= pre_cnt + 1'b1;
      end
   end

   // Blink timebase, counted in PWM frames. H = 0 parks the gate open; a
   // BLINK write restarts the half-period count but leaves the phase alone.
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         blink_cnt   <= '0;
         blink_phase <= 1'b1;
      end else if (blink_h == '0) begin
         blink_cnt   <= '0;
         blink_phase <= 1'b1;
      end else if (wr_blink) begin
         blink_cnt <= '0;
      end else if (frame_end) begin
         if (blink_cnt == (blink_h - BLINK_ONE)) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
         end else begin
            blink_cnt <= blink_cnt + 1'b1;
         end
      end
   end

   // Per-LED compare and output selection. Full-scale duty is forced on so
   // the LED never drops out for the single count where pwm_cnt == max.
   always_comb begin
      pwm_vec = '0;
      for (int i = 0; i < NUM_LEDS; i++) begin
         pwm_vec[i] = (duty[i] == PWM_MAX) ? 1'b1 : (pwm_cnt < duty[i]);
      end
      gate     = enable & (blink_en ? blink_phase : 1'b1);
      led_next = {NUM_LEDS{gate}} & ((mode & pwm_vec) | (~mode & static_val));
   end

   // LED pins are registered to keep the pad outputs glitch-free.
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         led_out <= '0;
      end else begin
         led_out <= led_next;
      end
   end

   // Read mux, evaluated on the current (pre-write) register contents so a
   // read and write to the same address in one cycle returns the old value.
   always_comb begin
      read_word = '0;
      case (avs_address)
         5'h00:   read_word = {30'b0, blink_en, enable};
         5'h01:   read_word = 32'(static_val);
         5'h02:   read_word = 32'(prescale);
         5'h03:   read_word = 32'(blink_h);
         5'h04:   read_word = 32'(mode);
         5'h05:   read_word = 32'(led_out) | (32'(blink_phase) << 16);
         default: read_word = '0;
      endcase
      for (int i = 0; i < NUM_LEDS; i++) begin
         if (avs_address == 5'(i + 8)) begin
            read_word = 32'(duty[i]);
         end
      end
   end

   // Read data register: loads only on a read strobe and holds otherwise.
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         avs_readdata <= '0;
      end else if (avs_read) begin
         avs_readdata <= read_word;
      end
   end

endmodule
